p_mul_stream_bridge: RTL and testbench
======================================

Name: p_mul_stream_bridge

Overview:
- Word-serial front end for the P_MUL datapath.
- Collects operands as 16-bit words on a valid/ready stream and drives them onto the P_MUL operand interface (in_1/in_2/in_3/in_valid).
- Captures the 96-bit result (out/out_valid) and returns it as 16-bit words on an output stream.
- Sits between the host word bus and P_MUL; one transaction in flight.

Parameters:
WORD_W, 16, stream word width
IN1_W, 47, width of in_1
IN2_W, 47, width of in_2
IN3_W, 48, width of in_3
OUT_W, 96, width of P_MUL result
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with optional feature)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
s_valid  input  1  operand word valid
s_ready  output  1  bridge accepts operand word
s_data  input  WORD_W  operand word
m_valid  output  1  result word valid
m_ready  input  1  sink accepts result word
m_data  output  WORD_W  result word
m_last  output  1  marks final result word
in_1  output  IN1_W  operand to P_MUL
in_2  output  IN2_W  operand to P_MUL
in_3  output  IN3_W  operand to P_MUL
in_valid  output  1  one-cycle operand strobe to P_MUL
out  input  OUT_W  P_MUL result
out_valid  input  1  P_MUL result strobe
busy  output  1  high in ISSUE, WAIT, SEND
err  output  1  sticky error flag

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous, active-high.
- Reset values: state=LOAD, word count=0, operand and result registers=0; all outputs 0.
  - s_ready is forced 0 while rst=1.
  - s_ready is 1 in the first cycle after rst deasserts.
- Operand packing:
  - Vector V = {in_3, in_2, in_1} is 142 bits, zero-padded to 144 bits, sent as 9 words, least-significant word first.
  - Word k fills V[16k+15:16k].
  - Bits 142-143 of word 8 are ignored.
- Result packing: out is split into 6 words, least-significant word first; m_last=1 only on word 5.
- Handshakes:
  - A transfer occurs on a cycle where valid and ready are both 1.
  - m_valid, once high, stays high with m_data and m_last stable until accepted.
- FSM states:
  - LOAD: s_ready=1. Each accepted word is stored at the current count, and the count increments. On acceptance of word 8 -> ISSUE.
  - ISSUE: in_valid=1 for exactly this one cycle; s_ready=0 -> WAIT. in_valid is asserted the cycle after the 9th word is accepted.
  - WAIT: s_ready=0, in_valid=0. On out_valid=1, capture out -> SEND. m_valid rises the next cycle.
  - SEND: m_valid=1, m_data=result word[idx]. On each accept, idx increments. Accept of idx 5 -> LOAD, with count and idx cleared.
- in_1/in_2/in_3 are driven from the operand register and held stable from ISSUE until the next ISSUE.
- Boundary conditions:
  - out_valid outside WAIT is ignored and sets err.
  - out_valid in the ISSUE cycle is also ignored and sets err.
  - rst asserted mid-transaction (any state) aborts it: partial operands are discarded, no in_valid is emitted, m_valid drops the next cycle, err clears.
  - s_valid held high in a non-LOAD state: no transfer, s_data is ignored.
  - m_ready held low indefinitely in SEND: the bridge stalls; out_valid strobes arriving meanwhile set err.
- err clears only on rst.

Optional Feature:
- Macro: P_MUL_BRIDGE_TIMEOUT_EN
- Defined:
  - A counter starts at 0 on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without out_valid: set err, return to LOAD with count cleared, emit no result words.
- Undefined: no counter; WAIT waits indefinitely; TIMEOUT_CYC is unused.

Test Plan:
- Basic transaction:
  - Stimulus: after rst, send 9 words encoding in_1=47'h1, in_2=47'h2, in_3=48'h3; model returns out=96'h9 after 4 cycles.
  - Required: in_valid is one cycle, the cycle after word 8 is accepted; in_1/in_2/in_3 match; m_data sequence 0009,0000,0000,0000,0000,0000 with m_last on the 6th word; err=0.
- Full-width packing:
  - Stimulus: in_1=all ones, in_2=0, in_3=48'hA5A5_A5A5_A5A5; result out=96'hFEDC_BA98_7654_3210_0123_4567.
  - Required: operand fields exact, pad bits ignored; words emitted 4567,0123,3210,7654,BA98,FEDC.
- Backpressure:
  - Stimulus: s_valid toggles every other cycle; m_ready low for 5 cycles per word.
  - Required: no word lost or duplicated; m_data stable while m_valid=1 and m_ready=0.
- Stray strobe:
  - Stimulus: out_valid pulse while in LOAD with 3 words loaded.
  - Required: err=1; loading continues; the transaction completes with correct data.
- Reset mid-operation:
  - Stimulus: assert rst in WAIT, then in SEND after 2 words.
  - Required: next cycle m_valid=0, in_valid=0, busy=0, s_ready=0 during rst; a fresh transaction afterwards is correct.
- Timeout (P_MUL_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=16):
  - Stimulus: no out_valid after ISSUE.
  - Required: err=1 and s_ready=1 after 16 WAIT cycles; with the macro undefined, still in WAIT (busy=1) after 100 cycles.

Source files
------------

// File: rtl/p_mul_stream_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : p_mul_stream_bridge                                        |
// | Description : Word-serial front end for P_MUL. Gathers a 142-bit operand |
// |               vector as 16-bit stream words, strobes it onto the P_MUL   |
// |               operand interface, captures the 96-bit result and returns  |
// |               it as 16-bit stream words. One transaction in flight.      |
// | Options     : P_MUL_BRIDGE_TIMEOUT_EN - WAIT watchdog of TIMEOUT_CYC     |
// |               cycles; expiry sets err and abandons the transaction.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module p_mul_stream_bridge #(
    parameter int WORD_W      = 16,
    parameter int IN1_W       = 47,
    parameter int IN2_W       = 47,
    parameter int IN3_W       = 48,
    parameter int OUT_W       = 96,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,
    output logic [IN1_W-1:0]  in_1,
    output logic [IN2_W-1:0]  in_2,
    output logic [IN3_W-1:0]  in_3,
    output logic              in_valid,
    input  logic [OUT_W-1:0]  out,
    input  logic              out_valid,
    output logic              busy,
    output logic              err
);

    localparam int c_vec_w     = IN1_W + IN2_W + IN3_W;
    localparam int c_in_words  = (c_vec_w + WORD_W - 1) / WORD_W;
    localparam int c_out_words = OUT_W / WORD_W;
    localparam int c_cnt_w     = $clog2(c_in_words);
    localparam int c_idx_w     = $clog2(c_out_words);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_in_words - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(c_out_words - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [c_cnt_w-1:0]                   r_count;
    logic [c_idx_w-1:0]                   r_idx;
    // The final operand word is taken straight from s_data, so only the
    // leading words need storage.
    logic [c_in_words-2:0][WORD_W-1:0]    r_op_words;
    logic [c_vec_w-1:0]                   r_op_hold;
    logic [c_out_words-1:0][WORD_W-1:0]   r_result;
    logic                                 r_err;

    logic w_s_fire;
    logic w_timeout;

    // Acceptance is decoded from state directly so it does not depend on the
    // combinational s_ready output; reset has priority in every register.
    assign w_s_fire = s_valid && (r_state == ST_LOAD);

`ifdef P_MUL_BRIDGE_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYC + 1);
    logic [c_to_w-1:0] r_wait_cnt;

    // Watchdog: cleared in ISSUE so it reads 0 on the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + c_to_w'(1);
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && !out_valid &&
                       (r_wait_cnt == c_to_w'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;

    // Without the watchdog TIMEOUT_CYC has no effect; referenced here so the
    // parameter list stays identical in both builds.
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake/strobe outputs.
    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        in_valid     = 1'b0;
        m_valid      = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_LOAD: begin
                s_ready = !rst;
                if (w_s_fire && (r_count == c_cnt_last)) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy         = 1'b1;
                in_valid     = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (out_valid) begin
                    w_state_next = ST_SEND;
                end else if (w_timeout) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_SEND: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                if (m_ready && (r_idx == c_idx_last)) begin
                    w_state_next = ST_LOAD;
                end
            end
            default: begin
                w_state_next = ST_LOAD;
            end
        endcase
    end

    // Operand collection, result capture, word index and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_idx      <= '0;
            r_op_words <= '0;
            r_op_hold  <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_s_fire) begin
                if (r_count == c_cnt_last) begin
                    // Pad bits above the vector fall off in the truncation.
                    r_count   <= '0;
                    r_op_hold <= c_vec_w'({s_data, r_op_words});
                end else begin
                    r_count <= r_count + c_cnt_w'(1);
                    for (int k = 0; k < c_in_words - 1; k++) begin
                        if (r_count == c_cnt_w'(k)) begin
                            r_op_words[k] <= s_data;
                        end
                    end
                end
            end
            if ((r_state == ST_WAIT) && out_valid) begin
                r_result <= out;
            end
            if ((r_state == ST_SEND) && m_ready) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
            end
            if ((out_valid && (r_state != ST_WAIT)) || w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Result word select for the output stream.
    always_comb begin
        m_data = '0;
        for (int k = 0; k < c_out_words; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                m_data = r_result[k];
            end
        end
    end

    assign m_last = (r_state == ST_SEND) && (r_idx == c_idx_last);
    assign in_1   = r_op_hold[IN1_W-1:0];
    assign in_2   = r_op_hold[IN1_W +: IN2_W];
    assign in_3   = r_op_hold[IN1_W + IN2_W +: IN3_W];
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_p_mul_stream_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_p_mul_stream_bridge                                     |
// | Description : Self-checking bench for p_mul_stream_bridge: table of      |
// |               directed transactions plus reset/timeout sequences.        |
// |               Honours P_MUL_BRIDGE_TIMEOUT_EN (watchdog of 16 cycles).   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_p_mul_stream_bridge;

`ifdef P_MUL_BRIDGE_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic [46:0] in_1;
    logic [46:0] in_2;
    logic [47:0] in_3;
    logic        in_valid;
    logic [95:0] out;
    logic        out_valid;
    logic        busy;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [46:0]       a;
        logic [46:0]       b;
        logic [47:0]       c;
        logic [95:0]       res;
        logic [5:0][15:0]  exp_w;
        int                gap;
        int                stall;
        int                stray_at;
        logic              exp_err;
    } vec_t;

    vec_t tbl [4];

    p_mul_stream_bridge #(
        .WORD_W      (16),
        .IN1_W       (47),
        .IN2_W       (47),
        .IN3_W       (48),
        .OUT_W       (96),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .in_1      (in_1),
        .in_2      (in_2),
        .in_3      (in_3),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send the 9 operand words; returns in the first WAIT cycle with junk
    // still offered on the input stream.
    task automatic send_ops(input vec_t v);
        logic [143:0] p;
        p = {2'b11, v.c, v.b, v.a};
        for (int k = 0; k < 9; k++) begin
            if (k == v.stray_at) begin
                s_valid   = 1'b0;
                out_valid = 1'b1;
                out       = 96'hBAD0_0000_0000_0000_0000_0BAD;
                tick();
                out_valid = 1'b0;
                check("stray_err", 128'(err), 128'(1'b1));
                check("stray_busy", 128'(busy), 128'(1'b0));
            end
            if (v.gap != 0) begin
                s_valid = 1'b0;
                s_data  = 16'hFFFF;
                tick();
            end
            s_valid = 1'b1;
            s_data  = p[k*16 +: 16];
            check("s_ready_load", 128'(s_ready), 128'(1'b1));
            tick();
        end
        s_data = 16'hDEAD;
        check("issue_in_valid", 128'(in_valid), 128'(1'b1));
        check("issue_in_1", 128'(in_1), 128'(v.a));
        check("issue_in_2", 128'(in_2), 128'(v.b));
        check("issue_in_3", 128'(in_3), 128'(v.c));
        check("issue_s_ready", 128'(s_ready), 128'(1'b0));
        check("issue_busy", 128'(busy), 128'(1'b1));
        tick();
        check("wait_in_valid", 128'(in_valid), 128'(1'b0));
        check("wait_busy", 128'(busy), 128'(1'b1));
        check("wait_s_ready", 128'(s_ready), 128'(1'b0));
    endtask

    // P_MUL model: result strobe 4 cycles after the in_valid cycle.
    task automatic return_result(input vec_t v);
        repeat (3) tick();
        check("wait_in_1_hold", 128'(in_1), 128'(v.a));
        out_valid = 1'b1;
        out       = v.res;
        tick();
        out_valid = 1'b0;
        s_valid   = 1'b0;
        check("send_m_valid", 128'(m_valid), 128'(1'b1));
    endtask

    task automatic recv_words(input vec_t v, input int n);
        for (int j = 0; j < n; j++) begin
            for (int s = 0; s < v.stall; s++) begin
                m_ready = 1'b0;
                check("stall_m_valid", 128'(m_valid), 128'(1'b1));
                check("stall_m_data", 128'(m_data), 128'(v.exp_w[j]));
                tick();
            end
            m_ready = 1'b1;
            check("m_valid", 128'(m_valid), 128'(1'b1));
            check("m_data", 128'(m_data), 128'(v.exp_w[j]));
            check("m_last", 128'(m_last), 128'(j == 5));
            tick();
        end
        m_ready = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        send_ops(v);
        return_result(v);
        recv_words(v, 6);
        check("done_s_ready", 128'(s_ready), 128'(1'b1));
        check("done_busy", 128'(busy), 128'(1'b0));
        check("done_m_valid", 128'(m_valid), 128'(1'b0));
        check("done_err", 128'(err), 128'(v.exp_err));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("rst_s_ready", 128'(s_ready), 128'(1'b0));
        @(posedge clk);
        #1;
        check("rst_m_valid", 128'(m_valid), 128'(1'b0));
        check("rst_in_valid", 128'(in_valid), 128'(1'b0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_err", 128'(err), 128'(1'b0));
        check("rst_m_last", 128'(m_last), 128'(1'b0));
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 128'(s_ready), 128'(1'b1));
    endtask

    initial begin
        tbl[0] = '{a: 47'h1, b: 47'h2, c: 48'h3, res: 96'h9,
                   exp_w: {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0009},
                   gap: 0, stall: 0, stray_at: -1, exp_err: 1'b0};
        tbl[1] = '{a: 47'h7FFF_FFFF_FFFF, b: 47'h0, c: 48'hA5A5_A5A5_A5A5,
                   res: 96'hFEDC_BA98_7654_3210_0123_4567,
                   exp_w: {16'hFEDC, 16'hBA98, 16'h7654, 16'h3210, 16'h0123, 16'h4567},
                   gap: 0, stall: 0, stray_at: -1, exp_err: 1'b0};
        tbl[2] = '{a: 47'h1234_5678_9ABC, b: 47'h0FED_CBA9_8765, c: 48'hDEAD_BEEF_CAFE,
                   res: 96'h1111_2222_3333_4444_5555_6666,
                   exp_w: {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666},
                   gap: 1, stall: 5, stray_at: -1, exp_err: 1'b0};
        tbl[3] = '{a: 47'h5, b: 47'h6, c: 48'h7, res: 96'hABCD_0000_0000_0000_0000_0042,
                   exp_w: {16'hABCD, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0042},
                   gap: 0, stall: 0, stray_at: 3, exp_err: 1'b1};

        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        out       = '0;
        out_valid = 1'b0;
        repeat (3) tick();
        check("reset_s_ready", 128'(s_ready), 128'(1'b0));
        check("reset_m_valid", 128'(m_valid), 128'(1'b0));
        check("reset_in_valid", 128'(in_valid), 128'(1'b0));
        check("reset_busy", 128'(busy), 128'(1'b0));
        check("reset_err", 128'(err), 128'(1'b0));
        check("reset_in_1", 128'(in_1), 128'(0));
        check("reset_m_data", 128'(m_data), 128'(0));
        rst = 1'b0;
        #1;
        check("first_s_ready", 128'(s_ready), 128'(1'b1));

        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i]);
        end

        // Reset while waiting for P_MUL; err from the stray strobe must clear.
        send_ops(tbl[2]);
        s_valid = 1'b0;
        tick();
        pulse_reset();

        // Reset in SEND after two result words, then a clean transaction.
        send_ops(tbl[1]);
        return_result(tbl[1]);
        recv_words(tbl[1], 2);
        pulse_reset();
        run_txn(tbl[0]);

`ifdef P_MUL_BRIDGE_TIMEOUT_EN
        send_ops(tbl[0]);
        s_valid = 1'b0;
        repeat (15) tick();
        check("to_busy_before", 128'(busy), 128'(1'b1));
        check("to_err_before", 128'(err), 128'(1'b0));
        tick();
        check("to_s_ready", 128'(s_ready), 128'(1'b1));
        check("to_err", 128'(err), 128'(1'b1));
        check("to_busy", 128'(busy), 128'(1'b0));
        repeat (3) tick();
        check("to_no_result", 128'(m_valid), 128'(1'b0));
`else
        send_ops(tbl[0]);
        s_valid = 1'b0;
        repeat (100) tick();
        check("nto_busy", 128'(busy), 128'(1'b1));
        check("nto_s_ready", 128'(s_ready), 128'(1'b0));
        check("nto_m_valid", 128'(m_valid), 128'(1'b0));
`endif
        pulse_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
